// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared index types and constants for the 16-entry register file
package regfile_pkg;
  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS  = 16;
  localparam int ZERO_REG  = 15;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/mux16_1.sv
// rtl/mux16_1.sv - single-bit 16:1 read multiplexer cell
module mux16_1 (
  input  logic [15:0] d,
  input  logic [3:0]  sel,
  output logic        y
);
  assign y = d[sel];
endmodule

// File: rtl/regfile_word.sv
// rtl/regfile_word.sv - one WIDTH-bit register with async active-high clear and write enable
module regfile_word #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/regfile16.sv
// rtl/regfile16.sv - 16 x WIDTH register file, one write port, two combinational read ports
// with same-cycle write bypass and a hardwired zero entry.
module regfile16
  import regfile_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  reg_idx_t         wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  reg_idx_t         rd_addr_a,
  input  reg_idx_t         rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b
);
  localparam reg_idx_t ZERO_IDX = reg_idx_t'(ZERO_REG);

  logic [NUM_REGS-1:0] wr_sel;
  logic [WIDTH-1:0]    word_val [NUM_REGS];
  logic [WIDTH-1:0]    mux_a;
  logic [WIDTH-1:0]    mux_b;
  logic                byp_a;
  logic                byp_b;

  always_comb begin
    wr_sel = '0;
    if (wr_en) wr_sel[wr_addr] = 1'b1;
    wr_sel[ZERO_IDX] = 1'b0;
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_word
    logic word_en;
    // The zero entry keeps its storage so every slot is uniform, but can never be written.
    if (r == ZERO_REG) begin : g_zero
      assign word_en = 1'b0;
    end else begin : g_live
      assign word_en = wr_sel[r];
    end

    regfile_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .reset (reset),
      .en    (word_en),
      .d     (wr_data),
      .q     (word_val[r])
    );
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [NUM_REGS-1:0] slice;
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_tap
      assign slice[r] = word_val[r][b];
    end

    mux16_1 u_mux_a (.d(slice), .sel(rd_addr_a), .y(mux_a[b]));
    mux16_1 u_mux_b (.d(slice), .sel(rd_addr_b), .y(mux_b[b]));
  end

  assign byp_a = wr_en && (wr_addr == rd_addr_a) && (wr_addr != ZERO_IDX);
  assign byp_b = wr_en && (wr_addr == rd_addr_b) && (wr_addr != ZERO_IDX);

  // Zero index and reset override everything, including a matching bypass.
  always_comb begin
    rd_data_a = mux_a;
    if (byp_a) rd_data_a = wr_data;
    if (reset || (rd_addr_a == ZERO_IDX)) rd_data_a = '0;

    rd_data_b = mux_b;
    if (byp_b) rd_data_b = wr_data;
    if (reset || (rd_addr_b == ZERO_IDX)) rd_data_b = '0;
  end
endmodule

// File: tb/tb_regfile16.sv
// tb/tb_regfile16.sv - directed self-checking bench for regfile16
module tb_regfile16;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [3:0]   rd_addr_a;
  logic [3:0]   rd_addr_b;
  logic [W-1:0] rd_data_a;
  logic [W-1:0] rd_data_b;

  int checks   = 0;
  int failures = 0;

  regfile16 #(.WIDTH(W), .ZERO_REG(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  logic [W-1:0] exp_a, exp_b;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    tick(); tick();
    check("reset_state_a0", rd_data_a, 64'h0);
    reset = 1'b0;
    #1;
    rd_addr_a = 4'd9; rd_addr_b = 4'd14; #1;
    check("after_reset_a9", rd_data_a, 64'h0);
    check("after_reset_b14", rd_data_b, 64'h0);

    // Preload all ones, then clear with reset between edges.
    for (int i = 0; i < 16; i++) write_reg(4'(i), {W{1'b1}});
    rd_addr_a = 4'd5; rd_addr_b = 4'd15; #1;
    check("preload_a5", rd_data_a, {W{1'b1}});
    check("preload_b15_zero", rd_data_b, 64'h0);
    @(negedge clk); #2;
    reset = 1'b1; #1;
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i); rd_addr_b = 4'(15 - i); #1;
      check($sformatf("async_reset_a%0d", i), rd_data_a, 64'h0);
      check($sformatf("async_reset_b%0d", 15 - i), rd_data_b, 64'h0);
    end
    tick();
    reset = 1'b0;
    #1;

    write_reg(4'd3, 64'h0123_4567_89AB_CDEF);
    rd_addr_a = 4'd3; rd_addr_b = 4'd4; #1;
    check("wr_rd_a3", rd_data_a, 64'h0123_4567_89AB_CDEF);
    check("wr_rd_b4", rd_data_b, 64'h0);

    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 64'hDEAD;
    rd_addr_a = 4'd7; rd_addr_b = 4'd7; #1;
    check("bypass_a7", rd_data_a, 64'hDEAD);
    check("bypass_b7", rd_data_b, 64'hDEAD);
    rd_addr_b = 4'd3; #1;
    check("bypass_other_b3", rd_data_b, 64'h0123_4567_89AB_CDEF);
    tick();
    wr_en = 1'b0; rd_addr_b = 4'd7; #1;
    check("committed_a7", rd_data_a, 64'hDEAD);
    check("committed_b7", rd_data_b, 64'hDEAD);

    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 64'h55;
    rd_addr_a = 4'd15; rd_addr_b = 4'd15; #1;
    check("zero_nobypass_a", rd_data_a, 64'h0);
    check("zero_nobypass_b", rd_data_b, 64'h0);
    tick();
    wr_en = 1'b0; #1;
    check("zero_later_a", rd_data_a, 64'h0);

    write_reg(4'd2, 64'h1234);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 64'hAA;
    rd_addr_a = 4'd2; reset = 1'b1; #1;
    check("reset_suppress_bypass", rd_data_a, 64'h0);
    tick();
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0; #1;
    check("reset_race_reg2", rd_data_a, 64'h0);

    for (int i = 0; i < 16; i++) write_reg(4'(i), 64'(i) * 64'h1111);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        rd_addr_a = 4'(a); rd_addr_b = 4'(b); #1;
        exp_a = (a == 15) ? 64'h0 : 64'(a) * 64'h1111;
        exp_b = (b == 15) ? 64'h0 : 64'(b) * 64'h1111;
        check($sformatf("sweep_a%0d_b%0d_a", a, b), rd_data_a, exp_a);
        check($sformatf("sweep_a%0d_b%0d_b", a, b), rd_data_b, exp_b);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
